pir_emulator: RTL and testbench

- Behavioural source of a PIR sensor output, modelled on an HC-SR501-style module: warm-up lockout, hold time, optional retrigger, and a post-hold block time.
- Drives the `pirSensor` input of the motion-detect FSM in lab builds and benches, replacing the physical sensor.
- A raw motion stimulus (push-button, switch or testbench) is shaped into a sensor-faithful output pulse.

---
 rtl/pir_emulator.sv | 114 +++++++++++
 tb/tb_pir_emulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pir_emulator.sv
// Behavioural PIR sensor model: warm-up lockout, hold time, optional retrigger, post-hold block.
// Define PIR_EVT_SYNC_EN to pass motion_evt through a 2-flop synchroniser.
module pir_emulator #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned BLOCK_CYCLES  = 25_000_000,
    parameter int unsigned WARMUP_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       motion_evt,
    input  logic       retrig_mode,
    output logic       pir_out,
    output logic [1:0] state_o,
    output logic [7:0] trig_count
);

    localparam int unsigned MAX_HB = (HOLD_CYCLES > BLOCK_CYCLES) ? HOLD_CYCLES : BLOCK_CYCLES;
    localparam int unsigned MAX_P  = (MAX_HB > WARMUP_CYCLES) ? MAX_HB : WARMUP_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLOCK_LD = (BLOCK_CYCLES == 0) ? '0 : CW'(BLOCK_CYCLES - 1);
    localparam logic [CW-1:0] WARM_LD  = (WARMUP_CYCLES == 0) ? '0 : CW'(WARMUP_CYCLES - 1);
    localparam bit            NO_BLOCK = (BLOCK_CYCLES == 0);

    typedef enum logic [1:0] {
        S_WARMUP = 2'b00,
        S_IDLE   = 2'b01,
        S_HOLD   = 2'b10,
        S_BLOCK  = 2'b11
    } state_t;

    localparam state_t RST_STATE = (WARMUP_CYCLES == 0) ? S_IDLE : S_WARMUP;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          trig;
    logic          evt_s;

`ifdef PIR_EVT_SYNC_EN
    logic [1:0] evt_sync;

    // Two-flop synchroniser for the asynchronous stimulus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_sync <= 2'b00;
        end else begin
            evt_sync <= {evt_sync[0], motion_evt};
        end
    end

    assign evt_s = evt_sync[1];
`else
    assign evt_s = motion_evt;
`endif

    // State, shared down-counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            cnt        <= WARM_LD;
            pir_out    <= 1'b0;
            trig_count <= 8'd0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pir_out <= (state_d == S_HOLD);
            if (trig) begin
                trig_count <= trig_count + 8'd1;
            end
        end
    end

    // Next-state and counter control
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        trig    = 1'b0;
        case (state)
            S_WARMUP, S_BLOCK: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_IDLE: begin
                if (evt_s) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    trig    = 1'b1;
                end
            end
            S_HOLD: begin
                if (retrig_mode && evt_s) begin
                    cnt_d = HOLD_LD;
                end else if (cnt == '0) begin
                    if (NO_BLOCK) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BLOCK;
                        cnt_d   = BLOCK_LD;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_pir_emulator.sv
// Scoreboard bench for pir_emulator: expected output transitions are queued by the
// stimulus and matched by a monitor on every change of {pir_out, state_o}.
module tb_pir_emulator;

    localparam int H = 8;
    localparam int B = 4;
    localparam int W = 16;
`ifdef PIR_EVT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam logic [1:0] ST_WARMUP = 2'b00;
    localparam logic [1:0] ST_IDLE   = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;
    localparam logic [1:0] ST_BLOCK  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       motion_evt;
    logic       retrig_mode;
    logic       pir_out;
    logic [1:0] state_o;
    logic [7:0] trig_count;

    typedef struct {
        logic       pir;
        logic [1:0] st;
        int         cyc;
        logic [7:0] tc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_tc = 8'd0;
    logic [2:0] prev = 3'b000;

    pir_emulator #(
        .HOLD_CYCLES  (H),
        .BLOCK_CYCLES (B),
        .WARMUP_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .motion_evt (motion_evt),
        .retrig_mode(retrig_mode),
        .pir_out    (pir_out),
        .state_o    (state_o),
        .trig_count (trig_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every change of the observed outputs must match the next queued transition
    always @(negedge clk) begin
        exp_t e;
        if ({pir_out, state_o} !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got pir=%0d st=%0d tc=%0d at cyc %0d, required no change",
                         pir_out, state_o, trig_count, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.pir !== pir_out || e.st !== state_o || e.cyc != cyc || e.tc !== trig_count) begin
                    errors++;
                    $display("FAIL transition: got pir=%0d st=%0d tc=%0d cyc=%0d, required pir=%0d st=%0d tc=%0d cyc=%0d",
                             pir_out, state_o, trig_count, cyc, e.pir, e.st, e.tc, e.cyc);
                end
            end
            prev = {pir_out, state_o};
        end
    end

    task automatic push(input logic p, input logic [1:0] s, input int c, input logic [7:0] t);
        exp_t e;
        e.pir = p;
        e.st  = s;
        e.cyc = c;
        e.tc  = t;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic single_trigger();
        int k, r;
        @(negedge clk);
        k = cyc;
        motion_evt = 1'b1;
        exp_tc = exp_tc + 8'd1;
        r = k + LAT;
        push(1'b1, ST_HOLD,  r,         exp_tc);
        push(1'b0, ST_BLOCK, r + H,     exp_tc);
        push(1'b0, ST_IDLE,  r + H + B, exp_tc);
        @(negedge clk);
        motion_evt = 1'b0;
        wait_until(r + H + B + 2);
    endtask

    // Three 1-clock pulses spaced 5 clocks apart
    task automatic pulse_train(input logic rm);
        int k, r, f;
        @(negedge clk);
        retrig_mode = rm;
        k = cyc;
        exp_tc = exp_tc + 8'd1;
        r = k + LAT;
        f = rm ? (k + 10 + LAT + H) : (r + H);
        push(1'b1, ST_HOLD,  r,     exp_tc);
        push(1'b0, ST_BLOCK, f,     exp_tc);
        push(1'b0, ST_IDLE,  f + B, exp_tc);
        for (int p = 0; p < 3; p++) begin
            motion_evt = 1'b1;
            @(negedge clk);
            motion_evt = 1'b0;
            if (p < 2) repeat (4) @(negedge clk);
        end
        wait_until(f + B + 2);
        retrig_mode = 1'b0;
    endtask

    initial begin
        int k, r;
        rst_n       = 1'b0;
        motion_evt  = 1'b0;
        retrig_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pir", int'(pir_out), 0);
        check("reset_tc", int'(trig_count), 0);
        check("reset_state", int'(state_o), int'(ST_WARMUP));

        // Warm-up lockout with the stimulus held from reset release
        motion_evt = 1'b1;
        @(negedge clk);
        k = cyc;
        rst_n = 1'b1;
        exp_tc = 8'd1;
        r = k + W + 1;
        push(1'b0, ST_IDLE,  k + W,     8'd0);
        push(1'b1, ST_HOLD,  r,         exp_tc);
        push(1'b0, ST_BLOCK, r + H,     exp_tc);
        push(1'b0, ST_IDLE,  r + H + B, exp_tc);
        wait_until(r);
        motion_evt = 1'b0;
        wait_until(r + H + B + 2);
        check("warmup_tc", int'(trig_count), 1);

        single_trigger();
        pulse_train(1'b1);
        check("retrig_tc", int'(trig_count), int'(exp_tc));
        pulse_train(1'b0);
        check("single_mode_tc", int'(trig_count), int'(exp_tc));

        // Reset asserted in the third HOLD clock
        @(negedge clk);
        k = cyc;
        motion_evt = 1'b1;
        r = k + LAT;
        push(1'b1, ST_HOLD, r, exp_tc + 8'd1);
        @(negedge clk);
        motion_evt = 1'b0;
        wait_until(r + 2);
        #2;
        rst_n = 1'b0;
        exp_tc = 8'd0;
        push(1'b0, ST_WARMUP, r + 3, 8'd0);
        #1;
        check("midhold_pir", int'(pir_out), 0);
        check("midhold_tc", int'(trig_count), 0);
        check("midhold_state", int'(state_o), int'(ST_WARMUP));
        repeat (2) @(negedge clk);
        k = cyc;
        rst_n = 1'b1;
        push(1'b0, ST_IDLE, k + W, 8'd0);
        wait_until(k + W + 1);

        // 256 triggers wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            single_trigger();
            if (i == 254) check("tc_255", int'(trig_count), 255);
        end
        check("tc_wrap", int'(trig_count), 0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
